// File: rtl/tow_pkg.sv
// Shared types and 7-segment patterns for the tug-of-war datapath.
package tow_pkg;

  typedef enum logic [1:0] {PLAY, ROUND_END, MATCH_OVER} score_state_t;
  typedef enum logic [1:0] {WIN_NONE = 2'b00, WIN_L = 2'b01, WIN_R = 2'b10} winner_t;

  // Wide enough for the largest legal hold (255 cycles).
  localparam int unsigned HoldW = 8;

  // Active-high segments, bit0 = a .. bit6 = g.
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_dec.sv
// 4-bit binary to 7-segment decoder; digits 0..9, anything above is blank.
module seg7_dec
  import tow_pkg::*;
(
  input  logic [3:0] bin_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bin_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/match_scoreboard.sv
// Round/match scorer for tug-of-war: detects round wins, holds after each round,
// declares the match winner and drives one score digit per side.
module match_scoreboard
  import tow_pkg::*;
#(
  parameter int unsigned WIN_TARGET  = 5,
  parameter int unsigned SCORE_W     = 4,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               edge_l,
  input  logic               edge_r,
  input  logic               press_l,
  input  logic               press_r,
  input  logic               new_match,
  output logic               play_again,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               match_over,
  output logic [1:0]         winner,
  output logic [6:0]         hex_l,
  output logic [6:0]         hex_r
);

  localparam logic [SCORE_W-1:0] Target    = SCORE_W'(WIN_TARGET);
  localparam logic [HoldW-1:0]   HoldReload = HoldW'(HOLD_CYCLES - 1);

  score_state_t       state_q, state_d;
  winner_t            winner_q, winner_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic [HoldW-1:0]   cnt_q, cnt_d;
  logic               play_again_q, play_again_d;
  logic               match_over_q, match_over_d;

  logic win_l, win_r;

  // The press terms are mutually exclusive, so at most one side can qualify.
  assign win_l = edge_l & press_l & ~press_r;
  assign win_r = edge_r & press_r & ~press_l;

  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    cnt_d        = cnt_q;
    play_again_d = 1'b0;
    match_over_d = match_over_q;

    if (new_match) begin
      state_d      = PLAY;
      winner_d     = WIN_NONE;
      score_l_d    = '0;
      score_r_d    = '0;
      cnt_d        = '0;
      play_again_d = 1'b1;
      match_over_d = 1'b0;
    end else begin
      unique case (state_q)
        PLAY: begin
          if (win_l) begin
            if (score_l_q < Target) score_l_d = score_l_q + 1'b1;
            cnt_d   = HoldReload;
            state_d = ROUND_END;
          end else if (win_r) begin
            if (score_r_q < Target) score_r_d = score_r_q + 1'b1;
            cnt_d   = HoldReload;
            state_d = ROUND_END;
          end
        end
        ROUND_END: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (score_l_q == Target) begin
            state_d      = MATCH_OVER;
            winner_d     = WIN_L;
            match_over_d = 1'b1;
          end else if (score_r_q == Target) begin
            state_d      = MATCH_OVER;
            winner_d     = WIN_R;
            match_over_d = 1'b1;
          end else begin
            state_d      = PLAY;
            play_again_d = 1'b1;
          end
        end
        MATCH_OVER: begin
          match_over_d = 1'b1;
        end
        default: begin
          state_d = PLAY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= PLAY;
      winner_q     <= WIN_NONE;
      score_l_q    <= '0;
      score_r_q    <= '0;
      cnt_q        <= '0;
      play_again_q <= 1'b0;
      match_over_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      cnt_q        <= cnt_d;
      play_again_q <= play_again_d;
      match_over_q <= match_over_d;
    end
  end

  assign play_again = play_again_q;
  assign score_l    = score_l_q;
  assign score_r    = score_r_q;
  assign match_over = match_over_q;
  assign winner     = winner_q;

  seg7_dec u_seg_l (
    .bin_i (4'(score_l_q)),
    .seg_o (hex_l)
  );

  seg7_dec u_seg_r (
    .bin_i (4'(score_r_q)),
    .seg_o (hex_r)
  );

endmodule
